alu_control_mdu: RTL and testbench

Parametrised successor to the single-cycle ALU control decoder. It keeps the combinational `ALUOp`/funct decode to a 4-bit ALU control word, widens `funct7` to the full 7 bits, and flags illegal encodings instead of emitting X. It adds an XLEN-wide iterative RV32M multiply/divide unit (MDU) with a stall handshake toward the core. It sits between the main decoder and the execute stage, and its result feeds the writeback mux.

---
 rtl/alu_control_mdu.sv | 209 ++++++++++++++++++++
 tb/tb_alu_control_mdu.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_mdu.sv
// ALUOp/funct decode to a 4-bit ALU control word, plus an iterative RV32M multiply/divide unit.
// Define ALU_CTRL_DIV_EN to build in div/divu/rem/remu; otherwise those encodings decode as illegal.
module alu_control_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [3:0]      ALU_control,
  output logic            illegal,
  output logic            stall,
  output logic            md_busy,
  output logic            md_done,
  output logic [XLEN-1:0] md_result
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;
  localparam logic [3:0] C_ADD = 4'b0010, C_SUB = 4'b0110, C_XOR = 4'b0111, C_OR  = 4'b0001;
  localparam logic [3:0] C_AND = 4'b0000, C_SLL = 4'b0011, C_SRL = 4'b1000, C_SRA = 4'b1010;
  localparam logic [3:0] C_SLT = 4'b0100, C_SLTU = 4'b0101, C_MDU = 4'b1100, C_ILL = 4'b1111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     count_reg;
  logic [XLEN-1:0]   hi_reg, lo_reg, opnd_reg;
  logic [2:0]        op_reg;
  logic              neg_reg;
  logic              md_busy_reg, md_done_reg;
  logic [XLEN-1:0]   md_result_reg;

  logic [3:0]        base_code;
  logic              m_op;

  // funct3 -> operation for the funct7=0 / I-type forms
  always_comb begin
    base_code = C_ADD;
    case (funct3)
      3'b000:  base_code = C_ADD;
      3'b001:  base_code = C_SLL;
      3'b010:  base_code = C_SLT;
      3'b011:  base_code = C_SLTU;
      3'b100:  base_code = C_XOR;
      3'b101:  base_code = C_SRL;
      3'b110:  base_code = C_OR;
      default: base_code = C_AND;
    endcase
  end

  always_comb begin
    ALU_control = C_ILL;
    m_op        = 1'b0;
    case (ALUOp)
      2'b00: ALU_control = C_ADD;
      2'b01: ALU_control = C_SUB;
      2'b10: begin
        if (funct7 == F7_BASE) begin
          ALU_control = base_code;
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000)      ALU_control = C_SUB;
          else if (funct3 == 3'b101) ALU_control = C_SRA;
        end else if (funct7 == F7_MUL) begin
`ifdef ALU_CTRL_DIV_EN
          m_op = 1'b1;
`else
          m_op = !funct3[2];
`endif
          if (m_op) ALU_control = C_MDU;
        end
      end
      default: begin
        if (funct3 == 3'b001) begin
          if (funct7 == F7_BASE) ALU_control = C_SLL;
        end else if (funct3 == 3'b101) begin
          if (funct7 == F7_BASE)     ALU_control = C_SRL;
          else if (funct7 == F7_ALT) ALU_control = C_SRA;
        end else begin
          ALU_control = base_code;
        end
      end
    endcase
  end

  assign illegal = (ALU_control == C_ILL);

  logic            accept, a_signed, b_signed, a_neg, b_neg, neg_init;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            special;
  logic [XLEN-1:0] special_result;

  assign accept   = (state_reg == IDLE) && in_valid && m_op;
  assign stall    = accept || (state_reg == RUN);
  assign a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign a_neg    = a_signed && rs1[XLEN-1];
  assign b_neg    = b_signed && rs2[XLEN-1];
  assign a_mag    = a_neg ? -rs1 : rs1;
  assign b_mag    = b_neg ? -rs2 : rs2;

`ifdef ALU_CTRL_DIV_EN
  logic div_zero, div_ovf;
  assign div_zero = funct3[2] && (rs2 == '0);
  assign div_ovf  = funct3[2] && !funct3[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
  assign special  = div_zero || div_ovf;
  // Remainder takes the dividend's sign; quotient the XOR of both signs.
  assign neg_init = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
  always_comb begin
    if (funct3[1]) special_result = div_zero ? rs1 : '0;
    else           special_result = div_zero ? '1 : rs1;
  end
`else
  assign special        = 1'b0;
  assign neg_init       = a_neg ^ b_neg;
  assign special_result = '0;
`endif

  // One iteration: shift-add multiply or restoring divide over the shared hi/lo pair.
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] hi_step, lo_step;
`ifdef ALU_CTRL_DIV_EN
  logic [XLEN:0]   div_trial;
`endif
  always_comb begin
    mul_sum = {1'b0, hi_reg} + {1'b0, {XLEN{lo_reg[0]}} & opnd_reg};
    hi_step = mul_sum[XLEN:1];
    lo_step = {mul_sum[0], lo_reg[XLEN-1:1]};
`ifdef ALU_CTRL_DIV_EN
    div_trial = {hi_reg, lo_reg[XLEN-1]} - {1'b0, opnd_reg};
    if (op_reg[2]) begin
      hi_step = div_trial[XLEN] ? {hi_reg[XLEN-2:0], lo_reg[XLEN-1]} : div_trial[XLEN-1:0];
      lo_step = {lo_reg[XLEN-2:0], !div_trial[XLEN]};
    end
`endif
  end

  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   final_result;
`ifdef ALU_CTRL_DIV_EN
  logic [XLEN-1:0]   div_val;
`endif
  always_comb begin
    prod         = {hi_step, lo_step};
    prod_fix     = neg_reg ? -prod : prod;
    final_result = (op_reg == 3'b000) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
`ifdef ALU_CTRL_DIV_EN
    div_val = op_reg[1] ? hi_step : lo_step;
    if (op_reg[2]) final_result = neg_reg ? -div_val : div_val;
`endif
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = special ? DONE : RUN;
      RUN:     if (count_reg == CW'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      opnd_reg      <= '0;
      op_reg        <= '0;
      neg_reg       <= 1'b0;
      md_busy_reg   <= 1'b0;
      md_done_reg   <= 1'b0;
      md_result_reg <= '0;
    end else begin
      state_reg   <= state_next;
      md_busy_reg <= (state_next == RUN);
      md_done_reg <= (state_next == DONE);
      case (state_reg)
        IDLE: if (accept) begin
          op_reg    <= funct3;
          neg_reg   <= neg_init;
          count_reg <= CW'(XLEN);
          hi_reg    <= '0;
          // Divide keeps the dividend in lo and divisor in opnd; multiply the reverse.
          lo_reg    <= funct3[2] ? a_mag : b_mag;
          opnd_reg  <= funct3[2] ? b_mag : a_mag;
          if (special) md_result_reg <= special_result;
        end
        RUN: begin
          hi_reg    <= hi_step;
          lo_reg    <= lo_step;
          count_reg <= count_reg - CW'(1);
          if (count_reg == CW'(1)) md_result_reg <= final_result;
        end
        default: ;
      endcase
    end
  end

  assign md_busy   = md_busy_reg;
  assign md_done   = md_done_reg;
  assign md_result = md_result_reg;
endmodule

// File: tb/tb_alu_control_mdu.sv
// Bench for alu_control_mdu: random decode checks plus a queued scoreboard for MDU results and latency.
module tb_alu_control_mdu;
  localparam int XLEN = 32;
`ifdef ALU_CTRL_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic            clk = 1'b0;
  logic            rst, in_valid;
  logic [1:0]      ALUOp;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1, rs2;
  logic [3:0]      ALU_control;
  logic            illegal, stall, md_busy, md_done;
  logic [XLEN-1:0] md_result;

  alu_control_mdu #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .ALUOp(ALUOp), .funct7(funct7),
    .funct3(funct3), .rs1(rs1), .rs2(rs2), .ALU_control(ALU_control), .illegal(illegal),
    .stall(stall), .md_busy(md_busy), .md_done(md_done), .md_result(md_result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [3:0] ref_base(input logic [2:0] f3);
    case (f3)
      3'd0: return 4'b0010;
      3'd1: return 4'b0011;
      3'd2: return 4'b0100;
      3'd3: return 4'b0101;
      3'd4: return 4'b0111;
      3'd5: return 4'b1000;
      3'd6: return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] ref_code(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3);
    case (op)
      2'd0: return 4'b0010;
      2'd1: return 4'b0110;
      2'd2: begin
        if (f7 == 7'h00) return ref_base(f3);
        if (f7 == 7'h20) return (f3 == 3'd0) ? 4'b0110 : (f3 == 3'd5) ? 4'b1010 : 4'b1111;
        if (f7 == 7'h01) return (DIV_EN || !f3[2]) ? 4'b1100 : 4'b1111;
        return 4'b1111;
      end
      default: begin
        if (f3 == 3'd1) return (f7 == 7'h00) ? 4'b0011 : 4'b1111;
        if (f3 == 3'd5) return (f7 == 7'h00) ? 4'b1000 : (f7 == 7'h20) ? 4'b1010 : 4'b1111;
        return ref_base(f3);
      end
    endcase
  endfunction

  // Reference RV32M semantics using 64-bit arithmetic.
  function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, q;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return a;
        q = sa / sb;
        return q[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'h0;
        q = sa % sb;
        return q[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Monitor: every md_done pulse must match the oldest queued expectation, including its cycle.
  always @(negedge clk) begin
    if (md_done) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: md_done=1 at cycle %0d with result %h, expected no completion", cyc, md_result);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("mdu completion: result %h at cycle %0d (expected %h at %0d)", md_result, cyc, e.res, e.due);
        check("md_result", md_result, e.res);
        check("done_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic issue_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bit legal, spec;
    int busy_cnt, stall_cnt;
    bit ended;
    legal = DIV_EN || !f3[2];
    spec  = legal && f3[2] && ((b == 0) || (!f3[0] && a == MIN_NEG && b == 32'hFFFF_FFFF));
    @(negedge clk);
    ALUOp = 2'b10; funct7 = 7'h01; funct3 = f3; rs1 = a; rs2 = b; in_valid = 1'b1;
    #1;
    if (!legal) begin
      check("m_illegal_code", 32'(ALU_control), 32'hF);
      check("m_illegal_flag", 32'(illegal), 32'h1);
      check("m_illegal_stall", 32'(stall), 32'h0);
      @(posedge clk); #1;
      check("m_illegal_busy", 32'(md_busy), 32'h0);
      @(negedge clk);
      in_valid = 1'b0;
      return;
    end
    check("m_code", 32'(ALU_control), 32'hC);
    check("stall_accept", 32'(stall), 32'h1);
    sb_q.push_back('{res: ref_m(f3, a, b), due: cyc + (spec ? 1 : XLEN + 1)});
    busy_cnt = 0; stall_cnt = 1; ended = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (md_busy) busy_cnt++;
      if (!stall) begin ended = 1; break; end
      stall_cnt++;
    end
    if (!ended) begin
      n_checks++;
      $display("FAIL stall_timeout: stall still 1 after 100 cycles, expected release");
    end
    check("busy_cycles", 32'(busy_cnt), spec ? 32'd0 : 32'(XLEN));
    check("stall_cycles", 32'(stall_cnt), spec ? 32'd1 : 32'(XLEN + 1));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic [6:0]  f7_pick;
    logic [3:0]  exp_code;
    rst = 1'b1; in_valid = 1'b0; ALUOp = 2'b00; funct7 = '0; funct3 = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(md_busy), 32'h0);
    check("reset_done", 32'(md_done), 32'h0);
    check("reset_result", md_result, 32'h0);
    check("reset_stall", 32'(stall), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed decode: sra legal, funct7=0100000 with funct3=110 illegal.
    ALUOp = 2'b10; funct7 = 7'h20; funct3 = 3'b101; in_valid = 1'b1;
    #1;
    check("sra_code", 32'(ALU_control), 32'hA);
    check("sra_illegal", 32'(illegal), 32'h0);
    check("sra_stall", 32'(stall), 32'h0);
    funct3 = 3'b110;
    #1;
    check("alt110_code", 32'(ALU_control), 32'hF);
    check("alt110_illegal", 32'(illegal), 32'h1);
    check("alt110_stall", 32'(stall), 32'h0);
    @(negedge clk);
    in_valid = 1'b0;

    // Random decode; non-M ops may be presented as valid and must never stall.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      case ($urandom_range(0, 3))
        0: f7_pick = 7'h00;
        1: f7_pick = 7'h20;
        2: f7_pick = 7'h01;
        default: f7_pick = 7'($urandom);
      endcase
      ALUOp = 2'($urandom); funct7 = f7_pick; funct3 = 3'($urandom);
      exp_code = ref_code(ALUOp, funct7, funct3);
      in_valid = (exp_code == 4'b1100) ? 1'b0 : 1'($urandom);
      #1;
      check("dec_code", 32'(ALU_control), 32'(exp_code));
      check("dec_illegal", 32'(illegal), 32'(exp_code == 4'b1111));
      check("dec_stall", 32'(stall), 32'h0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("dec_no_busy", 32'(md_busy), 32'h0);

    issue_m(3'd0, 32'd7, 32'hFFFF_FFFD);
    issue_m(3'd1, 32'd7, 32'hFFFF_FFFD);
    issue_m(3'd4, MIN_NEG, 32'hFFFF_FFFF);
    issue_m(3'd6, MIN_NEG, 32'hFFFF_FFFF);
    issue_m(3'd5, 32'd5, 32'd0);
    issue_m(3'd7, 32'd5, 32'd0);
    issue_m(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Reset in the middle of a mulhu: everything registered clears, nothing completes.
    @(negedge clk);
    ALUOp = 2'b10; funct7 = 7'h01; funct3 = 3'd3; rs1 = $urandom; rs2 = $urandom; in_valid = 1'b1;
    repeat (10) @(negedge clk);
    check("mid_busy_before_rst", 32'(md_busy), 32'h1);
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_busy", 32'(md_busy), 32'h0);
    check("rst_done", 32'(md_done), 32'h0);
    check("rst_result", md_result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    issue_m(3'd0, 32'd3, 32'd4);

    // Reset and a would-be accept in the same cycle: reset wins.
    @(negedge clk);
    rst = 1'b1; ALUOp = 2'b10; funct7 = 7'h01; funct3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    check("rst_accept_busy", 32'(md_busy), 32'h0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_accept_idle", 32'(md_busy), 32'h0);

    issue_m(3'd0, 32'd6, 32'd7);
    issue_m(3'd4, 32'd5, 32'd0);

    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 4))
        0: ra = 32'h0;
        1: ra = MIN_NEG;
        2: ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: rb = 32'h0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      issue_m(3'($urandom), ra, rb);
    end

    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
